instr_prefetch_queue: RTL
=========================

Name: instr_prefetch_queue

Overview:
- Fetch front-end that sits directly upstream of the decode stage of riscv_pipeline_cpu.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and buffers the in-order responses in a DEPTH-entry FIFO.
- Presents {instr, pc} to decode with a valid/ready handshake.
- On a taken branch or jump redirect from EX, it flushes the FIFO, discards responses still in flight, and restarts fetching at the new PC.

Parameters:
- XLEN, 32, instruction and address width.
- DEPTH, 4, FIFO entries; also the maximum number of outstanding requests. Must be a power of two and at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  taken branch or jump this cycle.
- redirect_pc  in  XLEN  new fetch target; bits [1:0] are ignored (forced to 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response beat; responses arrive in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  XLEN  fetched instruction.
- dec_valid  out  1  FIFO head valid.
- dec_instr  out  XLEN  head instruction; 32'h0000_0013 (NOP) when dec_valid=0.
- dec_pc  out  XLEN  PC of the head instruction; 0 when dec_valid=0.
- dec_ready  in  1  decode not stalled.

Behaviour:
- Reset is asynchronous, active-high, and applies whether asserted mid-operation or not. On reset:
  - state=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0.
  - imem_req_valid=0, dec_valid=0, dec_instr=NOP, dec_pc=0.
- State machine (registered):
  - BOOT: exactly one cycle after reset deassertion with no request issued, then → RUN.
  - RUN: normal fetching.
  - REDIR: entered the cycle after redirect_valid; lasts one cycle with no request issued, then → RUN.
  - redirect_valid in any state → REDIR, including while already in REDIR (re-latch the target).
- Request issue:
  - imem_req_valid = (state==RUN) && (fifo_count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - Request fire (valid && ready) → fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding++.
  - imem_req_valid does not depend combinationally on imem_req_ready or redirect_valid.
- Response handling:
  - On imem_rsp_valid: outstanding--.
  - If discard>0: drop the beat and decrement discard.
  - Otherwise push {data, pc}, where pc comes from a per-request PC tag FIFO (or a resp_pc counter initialised on redirect).
- Decode handshake:
  - dec_valid = !fifo_empty. Head pops when dec_valid && dec_ready.
  - Latency: a response received in cycle N appears on dec_* in cycle N+1.
  - No bypass from imem_rsp_data to dec_instr.
- Redirect cycle (redirect_valid=1):
  - FIFO is cleared, after any pop in that cycle has completed; a pop in the same cycle counts as consumed.
  - A response arriving in the same cycle is dropped.
  - discard_next = outstanding + req_fire − rsp_fire, excluding beats that were themselves already discarded.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - dec_valid=0 in the following cycle.
- Boundary conditions:
  - Full FIFO with a response arriving is impossible by construction (the issue rule caps count + outstanding at DEPTH). An assertion flags a violation.
  - Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
  - Pointer wrap-around is modulo DEPTH.
  - If imem_req_ready stays low, the request holds valid and addr stable until accepted or a redirect occurs. Redirect may drop valid without acceptance.
  - Counters outstanding and discard are clog2(DEPTH+1) bits wide, saturate-checked by assertion, and never underflow.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined: adds output ports stat_fetch_cnt[31:0] and stat_flush_cnt[31:0].
  - stat_fetch_cnt increments on each decode pop.
  - stat_flush_cnt increments on each redirect_valid cycle.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset release, memory with 1-cycle latency, ready=1, dec_ready=1:
   - First request at 0x0 two cycles after release.
   - dec_pc sequence 0x0, 0x4, 0x8… at one per cycle; dec_instr matches memory.
2. dec_ready=0 for 10 cycles:
   - Exactly DEPTH=4 entries are buffered (0x0–0xC) and requests stop.
   - After release, pops occur in order with no loss or duplication.
3. Memory latency 3 cycles with 3 requests outstanding, redirect_valid with redirect_pc=0x100:
   - All 3 stale responses are dropped.
   - Next dec_pc=0x100, then 0x104.
4. Redirect in the same cycle as a response beat and a decode pop:
   - The popped entry counts as delivered; the response is dropped.
   - dec_valid=0 in the next cycle; fetch resumes at the target.
5. redirect_pc=0x203:
   - imem_req_addr=0x200.
   - fetch_pc=0xFFFF_FFFC with a fire → next address 0x0.
6. Assert rst while requests are outstanding:
   - All outputs return to reset values immediately (asynchronously).
   - Fetching restarts at RESET_PC.
   - With PREFETCH_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Fetch front-end placed directly ahead of the decode stage. It issues
// sequential word fetches to instruction memory, buffers the in-order
// responses in a DEPTH-entry FIFO and hands {instr, pc} to decode. A taken
// branch/jump redirect flushes the FIFO, discards every response still in
// flight and restarts fetching at the (word-aligned) target.
//
// Optional build macro: PREFETCH_STATS_EN
//   When defined, adds stat_fetch_cnt (decode pops) and stat_flush_cnt
//   (redirect cycles). Both are 32-bit wrapping counters cleared by reset.
//
// Parameters:
//   XLEN      instruction / address width
//   DEPTH     FIFO entries and maximum outstanding requests (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   redirect_valid   taken branch/jump this cycle
//   redirect_pc      new fetch target (bits [1:0] ignored)
//   imem_req_valid   fetch request valid
//   imem_req_addr    word-aligned fetch address
//   imem_req_ready   memory accepts the request
//   imem_rsp_valid   in-order response beat
//   imem_rsp_data    fetched instruction
//   dec_valid        FIFO head valid
//   dec_instr        head instruction (NOP when dec_valid=0)
//   dec_pc           head PC (0 when dec_valid=0)
//   dec_ready        decode not stalled
//   stat_fetch_cnt   [PREFETCH_STATS_EN] decode pop count
//   stat_flush_cnt   [PREFETCH_STATS_EN] redirect count
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetch_cnt,
  output logic [31:0]     stat_flush_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Local parameters and types
  // ---------------------------------------------------------------------------
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);  // holds 0..DEPTH
  localparam int unsigned PTR_W = $clog2(DEPTH);      // wraps modulo DEPTH
  localparam int unsigned SUM_W = CNT_W + 1;          // count + outstanding

  localparam logic [XLEN-1:0]  NOP       = XLEN'(32'h0000_0013);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,       state_d;
  logic [XLEN-1:0]  fetch_pc_q,    fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q,     resp_pc_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0] count_q,       count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q,     discard_d;

  entry_t           fifo_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;
  entry_t          head;

  // The two low target bits are dropped by design.
  logic [1:0]      unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Issue only depends on registered state, never on ready or redirect, so
  // the request holds stable while memory back-pressures.
  assign imem_req_valid = (state_q == ST_RUN) &&
                          (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_SUM);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid;

  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid && dec_ready;

  // A beat is kept only when no stale beats remain ahead of it and no
  // redirect is flushing the queue in this very cycle.
  assign push = rsp_fire && (discard_q == '0) && !redirect_valid;

  assign head      = fifo_mem[rd_ptr_q];
  assign dec_instr = dec_valid ? head.instr : NOP;
  assign dec_pc    = dec_valid ? head.pc    : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    discard_d     = discard_q;

    // Sequencer: BOOT and REDIR are single quiet cycles before fetching.
    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_REDIR: state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase

    // Fetch address and tag of the next kept response.
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + XLEN'(4);
    end

    // Stale-beat bookkeeping.
    if (rsp_fire && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end

    // FIFO pointers and occupancy.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Redirect overrides everything above. The pop of this cycle has already
    // been consumed by decode; every request still in flight after this edge,
    // including one accepted right now, belongs to the old path.
    if (redirect_valid) begin
      state_d    = ST_REDIR;
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outstanding_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which entries
  // are meaningful, and the head is masked to NOP/0 whenever it is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{instr: imem_rsp_data, pc: resp_pc_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef PREFETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(pop);
    flush_cnt_d = flush_cnt_q + 32'(redirect_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stat_fetch_cnt = fetch_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // The issue rule caps count + outstanding at DEPTH, so a kept beat can never
  // meet a full FIFO unless the same cycle also frees a slot.
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == DEPTH_CNT)));

  a_no_outstanding_underflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_fire && (outstanding_q == '0)));

  a_no_outstanding_saturate: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && !rsp_fire && (outstanding_q == DEPTH_CNT)));

  a_discard_within_outstanding: assert property (@(posedge clk) disable iff (rst)
    discard_q <= outstanding_q);

endmodule
